sar_search_ctrl: RTL and testbench
==================================

# sar_search_ctrl

Successive-approximation search controller, driven by the flags of the team's 4-bit magnitude comparator. It drives the comparator's B operand with trial values and reads back the greater/less/equal flags. It then recovers the unknown value on A by binary search, MSB first. It sits beside the combinational comparator as the sequential, flag-consuming end of that interface, and it checks the flags for consistency.

## Interface
- WIDTH, 4, operand width; trial and result width, and the maximum number of search steps.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new search; sampled only in IDLE.
- a_gt_b  input  1  comparator flag, A > trial.
- a_lt_b  input  1  comparator flag, A < trial.
- a_eq_b  input  1  comparator flag, A == trial.
- trial  output  WIDTH  value driven to the comparator B input.
- busy  output  1  high while in TEST.
- done  output  1  one-cycle pulse when result, exact and err are valid.
- result  output  WIDTH  recovered value of A.
- exact  output  1  a_eq_b was observed during the search.
- err  output  1  flag combination was not one-hot; search aborted.

## Operation
- States: IDLE, TEST, DONE. Reset enters IDLE.
- IDLE: trial = 0.
  - start = 1 → TEST, with trial = 1 << (WIDTH-1), bit index = WIDTH-1, accumulator = 0.
  - Also clears result, exact and err.
- TEST, per cycle:
  - Flags are combinational from the current trial and are sampled on the next rising edge.
  - Flags not one-hot (none set, or more than one set): result = accumulator, err = 1, exact = 0 → DONE.
  - a_eq_b: result = trial, exact = 1 → DONE (early termination).
  - a_gt_b: the bit under test is kept (accumulator |= bit).
  - a_lt_b: the bit under test is cleared.
  - Bit index > 0: bit index decrements. Next trial = accumulator (after update) | (1 << new index).
  - Bit index == 0 and not equal: result = updated accumulator, exact = 0 → DONE.
- DONE: done = 1 for exactly one cycle, trial = 0, busy = 0 → IDLE.
- result, exact and err hold their values from DONE until the next accepted start.
- start while in TEST or DONE is ignored (not queued).
- Unsigned arithmetic only. No carry or overflow is possible, because trial bits are only ever set within WIDTH.

## Timing
- Reset values (asynchronous, immediate on rst_n low): trial = 0, result = 0, busy = 0, done = 0, exact = 0, err = 0, state IDLE.
- rst_n asserted mid-search aborts immediately to the reset values. No done pulse is generated.
- Latency from the start edge:
  - First trial is valid in the cycle after the start edge.
  - N TEST cycles, 1 ≤ N ≤ WIDTH.
  - done is high in cycle N+1 after the start edge.
  - Back in IDLE in cycle N+2.
- Minimum start-to-start spacing is N+2 cycles.
- busy is high exactly for the N TEST cycles.
- The comparator is combinational, so the flags must settle within the same cycle that trial is driven. No wait states.

## Test plan
- A = 1001, start pulse:
  - Trial sequence 1000, 1100, 1010, 1001.
  - done in cycle 5 with result = 1001, exact = 1, err = 0.
  - busy high for 4 cycles.
- A = 1000: first trial 1000 is equal → done in cycle 2 with result = 1000, exact = 1. Checks early termination.
- A = 0000:
  - Trials 1000, 0100, 0010, 0001, all lt.
  - result = 0000, exact = 0, err = 0 after 4 TEST cycles.
- A = 1111: trials 1000, 1100, 1110, 1111 → result = 1111, exact = 1. Then a start during the following DONE cycle must be ignored.
- Flag fault: force a_gt_b = a_lt_b = 1 on the 2nd TEST cycle.
  - err = 1, done pulses in cycle 3.
  - result = accumulator value (1000 for A = 1100).
  - Next start clears err.
- Reset mid-search:
  - Drop rst_n on the 3rd TEST cycle → all outputs 0 immediately, no done pulse.
  - After release, start with A = 0101 → result = 0101, exact = 1.

Source files
------------

// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: comparator-facing handshake between the SAR controller and its environment.
interface sar_search_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             exact;
    logic             err;
    modport master (
        input  start, a_gt_b, a_lt_b, a_eq_b,
        output trial, busy, done, result, exact, err
    );
    modport slave (
        output start, a_gt_b, a_lt_b, a_eq_b,
        input  trial, busy, done, result, exact, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first binary search of a comparator's A operand,
// driven by its gt/lt/eq flags, aborting on any non-one-hot flag set.
module sar_search_ctrl #(parameter int WIDTH = 4) (
    input logic               clk,
    input logic               rst_n,
    sar_search_ctrl_if.master bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] trial_q, acc_q, result_q, bit_d, acc_d;
    logic [IW-1:0]    idx_q;
    logic             busy_q, done_q, exact_q, err_q, onehot_d;
    assign bit_d    = ONE << idx_q;
    assign acc_d    = bus.a_gt_b ? (acc_q | bit_d) : acc_q;
    // xor is true for one or three flags set; exclude the all-set case
    assign onehot_d = (bus.a_gt_b ^ bus.a_lt_b ^ bus.a_eq_b) & ~(bus.a_gt_b & bus.a_lt_b & bus.a_eq_b);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    trial_q <= '0;
                    if (bus.start) begin
                        state_q  <= TEST;
                        trial_q  <= {1'b1, {(WIDTH-1){1'b0}}};
                        idx_q    <= IW'(WIDTH-1);
                        acc_q    <= '0;
                        result_q <= '0;
                        exact_q  <= 1'b0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                TEST: begin
                    if (!onehot_d || bus.a_eq_b || idx_q == '0) begin
                        state_q  <= DONE;
                        trial_q  <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= !onehot_d ? acc_q : bus.a_eq_b ? trial_q : acc_d;
                        exact_q  <= onehot_d && bus.a_eq_b;
                        err_q    <= !onehot_d;
                    end else begin
                        idx_q   <= idx_q - 1'b1;
                        acc_q   <= acc_d;
                        trial_q <= acc_d | (bit_d >> 1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.exact  = exact_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: directed searches against an arithmetic model of binary search,
// with a bench-side comparator that can inject flag faults.
module tb_sar_search_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] a_val = 4'd0;
    logic fault = 1'b0;
    bit chk_en = 1'b0;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;
    int done_at = -1;
    int done_cnt = 0;
    logic [3:0] trial_log[$];
    logic [3:0] exp_trial = 4'd0, exp_result = 4'd0;
    logic exp_busy = 1'b0, exp_done = 1'b0, exp_exact = 1'b0, exp_err = 1'b0;

    sar_search_ctrl_if #(.WIDTH(4)) bus();
    sar_search_ctrl #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    assign bus.a_gt_b = fault | (a_val > bus.trial);
    assign bus.a_lt_b = fault | (a_val < bus.trial);
    assign bus.a_eq_b = !fault && (a_val == bus.trial);

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // trial at step k holds A's top k bits plus the bit under test
    function automatic logic [3:0] trial_at(input logic [3:0] a, input int k);
        logic [3:0] hi;
        hi = 4'hF << (4 - k);
        return (a & hi) | (4'b1000 >> k);
    endfunction

    task automatic model(input logic [3:0] a, input int fault_at, output int n,
                         output logic [3:0] res, output logic ex, output logic er);
        logic [3:0] hi;
        n = 4; res = a; ex = 1'b0; er = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (fault_at == k + 1) begin
                hi = 4'hF << (4 - k);
                n = k + 1; res = a & hi; er = 1'b1;
                break;
            end
            if (trial_at(a, k) == a) begin
                n = k + 1; ex = 1'b1;
                break;
            end
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (rst_n) begin
            if (bus.busy) begin
                busy_cnt++;
                trial_log.push_back(bus.trial);
            end
            if (bus.done) done_at = cyc - start_cyc;
        end
        if (chk_en && rst_n) begin
            chk("trial", bus.trial, exp_trial);
            chk("busy", bus.busy, exp_busy);
            chk("done", bus.done, exp_done);
            chk("result", bus.result, exp_result);
            chk("exact", bus.exact, exp_exact);
            chk("err", bus.err, exp_err);
        end
    end

    // entered and left at posedge+1 of an idle cycle
    task automatic run(input logic [3:0] a, input int fault_at, input bit start_in_done);
        int n;
        logic [3:0] res;
        logic ex, er;
        model(a, fault_at, n, res, ex, er);
        a_val = a;
        busy_cnt = 0;
        done_at = -1;
        trial_log.delete();
        start_cyc = cyc;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            fault = (k == fault_at);
            exp_trial = trial_at(a, k - 1);
            exp_busy = 1'b1; exp_done = 1'b0;
            exp_result = 4'd0; exp_exact = 1'b0; exp_err = 1'b0;
            @(posedge clk); #1;
        end
        fault = 1'b0;
        exp_trial = 4'd0; exp_busy = 1'b0; exp_done = 1'b1;
        exp_result = res; exp_exact = ex; exp_err = er;
        if (start_in_done) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic chk_seq(input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk("trial_seq_len", trial_log.size(), 4);
        for (int i = 0; i < 4 && i < trial_log.size(); i++) chk("trial_seq", trial_log[i], e[i]);
    endtask

    initial begin
        int dc;
        bus.start = 1'b0;
        #3;
        chk("rst_trial", bus.trial, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        run(4'b1001, 0, 1'b0);
        chk_seq(4'b1000, 4'b1100, 4'b1010, 4'b1001);
        chk("lit_done_cycle_1001", done_at, 5);
        chk("lit_busy_cycles_1001", busy_cnt, 4);
        chk("lit_result_1001", bus.result, 4'b1001);
        chk("lit_exact_1001", bus.exact, 1);
        run(4'b1000, 0, 1'b0);
        chk("lit_done_cycle_1000", done_at, 2);
        chk("lit_result_1000", bus.result, 4'b1000);
        chk("lit_exact_1000", bus.exact, 1);
        run(4'b0000, 0, 1'b0);
        chk_seq(4'b1000, 4'b0100, 4'b0010, 4'b0001);
        chk("lit_result_0000", bus.result, 0);
        chk("lit_exact_0000", bus.exact, 0);
        chk("lit_err_0000", bus.err, 0);
        run(4'b1111, 0, 1'b1);
        chk_seq(4'b1000, 4'b1100, 4'b1110, 4'b1111);
        chk("lit_result_1111", bus.result, 4'b1111);
        chk("lit_ignored_start_busy", busy_cnt, 4);
        run(4'b1100, 2, 1'b0);
        chk("lit_fault_err", bus.err, 1);
        chk("lit_fault_done_cycle", done_at, 3);
        chk("lit_fault_result", bus.result, 4'b1000);
        run(4'b0110, 0, 1'b0);
        chk("lit_err_cleared", bus.err, 0);
        chk("lit_result_0110", bus.result, 4'b0110);
        chk_en = 1'b0;
        a_val = 4'b0110;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_busy", bus.busy, 1);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_trial", bus.trial, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_exact", bus.exact, 0);
        chk("mid_rst_err", bus.err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_trial = 4'd0; exp_busy = 1'b0; exp_done = 1'b0;
        exp_result = 4'd0; exp_exact = 1'b0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt, dc);
        chk_en = 1'b1;
        run(4'b0101, 0, 1'b0);
        chk("lit_result_0101", bus.result, 4'b0101);
        chk("lit_exact_0101", bus.exact, 1);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
